dm_arbiter: RTL
===============

DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter PROT_TOP, default 16'h0004: highest write-protected byte address; writes at addr <= PROT_TOP are refused.
REQ-002 Parameter MEM_TOP, default 16'h003E: highest legal halfword base address for reads and writes.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 pN_req  input  1  port N (N=0,1) requests a transaction.
REQ-006 pN_we  input  1  port N: 1 = write, 0 = read.
REQ-007 pN_addr  input  16  port N byte address; odd addresses are legal.
REQ-008 pN_wdata  input  16  port N write halfword, little-endian.
REQ-009 pN_gnt  output  1  port N: one-cycle pulse, command accepted.
REQ-010 pN_done  output  1  port N: one-cycle pulse, transaction complete.
REQ-011 pN_err  output  1  port N: valid with pN_done; transaction refused.
REQ-012 pN_rdata  output  16  port N read data; holds until that port's next done.
REQ-013 mem_we  output  1  data-memory write enable.
REQ-014 mem_addr  output  16  data-memory byte address.
REQ-015 mem_din  output  16  data-memory write data.
REQ-016 mem_dout  input  16  data-memory read data (combinational from mem_addr).

Function
REQ-017 FSM states are IDLE, BUSY and DONE, encoded in 2 bits.
REQ-018 In IDLE with no pN_req high, the FSM stays in IDLE.
REQ-019 In IDLE with one or both pN_req high, the FSM latches the winner's id, we, addr and wdata and goes to BUSY.
REQ-020 Arbitration: if only one port requests, that port wins.
REQ-021 Arbitration: if both ports request, the port named by the 1-bit priority pointer wins.
REQ-022 BUSY: the winner's pN_gnt is high for this one cycle.
REQ-023 BUSY: mem_addr = latched addr; mem_din = latched wdata.
REQ-024 BUSY: mem_we = 1 only if latched we=1 and PROT_TOP < addr <= MEM_TOP.
REQ-025 BUSY: for a read with addr <= MEM_TOP, mem_dout is captured into the winner's pN_rdata at the BUSY->DONE edge.
REQ-026 BUSY: for a read with addr > MEM_TOP, the winner's pN_rdata is loaded with 16'h0000.
REQ-027 BUSY always advances to DONE.
REQ-028 DONE: the winner's pN_done is high for one cycle.
REQ-029 DONE: pN_err = 1 for a refused write (addr <= PROT_TOP or addr > MEM_TOP) or a read with addr > MEM_TOP, else 0.
REQ-030 DONE: the priority pointer is set to the non-winning port, and the FSM returns to IDLE.
REQ-031 Latency: req sampled at edge k -> gnt during cycle k..k+1 -> done during cycle k+1..k+2; maximum throughput is 1 transaction per 3 cycles.
REQ-032 The requester holds its command stable until it sees gnt; changes after gnt are ignored.
REQ-033 A req still high in DONE is re-arbitrated in the following IDLE.
REQ-034 A loser's request is never dropped; with both ports requesting continuously, grants alternate 0,1,0,1.
REQ-035 Outside BUSY: mem_we = 0 and mem_addr/mem_din = 0.
REQ-036 At most one pN_gnt and one pN_done are high in any cycle.
REQ-037 Address arithmetic is unsigned 16-bit; addresses wrapping above 16'hFFFF are out of range (err).

Reset
REQ-038 While rst=1, asynchronously: FSM = IDLE, pointer = port 0, all gnt/done/err = 0, both pN_rdata = 0, mem_we = 0, mem_addr = 0, mem_din = 0.
REQ-039 A reset during BUSY or DONE aborts the transaction: no done pulse follows and no write occurs after rst rises.
REQ-040 After rst falls, the first arbitration happens at the first posedge clk.

Verification
REQ-041 Port 0 reads addr 0x0000 with memory preloaded 12 02 22 20 01 at bytes 0..4 -> p0_gnt then p0_done, p0_rdata=16'h0212, p0_err=0.
REQ-042 Port 1 writes 0xBEEF to 0x0010, then port 1 reads 0x0010 -> mem_we pulses once with mem_addr=0x0010; read returns 16'hBEEF, err=0 both times.
REQ-043 Port 0 writes 0xFFFF to 0x0003, then port 0 reads 0x0003 -> write: mem_we stays 0, p0_err=1; read: p0_rdata=16'h0120.
REQ-044 Port 1 reads 0x003F -> p1_rdata=16'h0000, p1_err=1.
REQ-045 Both ports hold req high for 12 cycles from reset -> grant order 0,1,0,1; exactly 4 done pulses; no overlap between ports.
REQ-046 Port 0 write to 0x0020 with rst asserted mid-BUSY -> mem_we drops immediately, no p0_done, pointer = 0 after reset.

Source files
------------

// File: rtl/dm_arbiter.sv
// Two-port arbiter in front of a single halfword data memory.
// Each accepted command runs IDLE -> BUSY -> DONE; a round-robin pointer breaks ties.
module dm_arbiter #(
    parameter logic [15:0] PROT_TOP = 16'h0004,
    parameter logic [15:0] MEM_TOP  = 16'h003E
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [15:0] p0_addr,
    input  logic [15:0] p0_wdata,
    output logic        p0_gnt,
    output logic        p0_done,
    output logic        p0_err,
    output logic [15:0] p0_rdata,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [15:0] p1_addr,
    input  logic [15:0] p1_wdata,
    output logic        p1_gnt,
    output logic        p1_done,
    output logic        p1_err,
    output logic [15:0] p1_rdata,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_din,
    input  logic [15:0] mem_dout
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic addr_readable(input logic [15:0] a);
        return (a <= MEM_TOP);
    endfunction

    function automatic logic addr_writable(input logic [15:0] a);
        return (a > PROT_TOP) && (a <= MEM_TOP);
    endfunction

    logic [1:0]  state_q,    state_d;
    logic        ptr_q,      ptr_d;
    logic        win_q,      win_d;
    logic        we_q,       we_d;
    logic [1:0]  gnt_q,      gnt_d;
    logic [1:0]  done_q,     done_d;
    logic [1:0]  err_q,      err_d;
    logic [15:0] rdata0_q,   rdata0_d;
    logic [15:0] rdata1_q,   rdata1_d;
    logic        mem_we_q,   mem_we_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [15:0] mem_din_q,  mem_din_d;

    logic [1:0]  req_s;
    logic        sel_s;
    logic        sel_we_s;
    logic [15:0] sel_addr_s;
    logic [15:0] sel_wdata_s;
    logic [15:0] rd_s;

    // Arbitration: a lone requester wins, a tie goes to the pointer.
    always_comb begin
        req_s = {p1_req, p0_req};
        if (req_s == 2'b11) begin
            sel_s = ptr_q;
        end else begin
            sel_s = req_s[1];
        end
        if (sel_s) begin
            sel_we_s    = p1_we;
            sel_addr_s  = p1_addr;
            sel_wdata_s = p1_wdata;
        end else begin
            sel_we_s    = p0_we;
            sel_addr_s  = p0_addr;
            sel_wdata_s = p0_wdata;
        end
    end

    // Next-state and next-output logic; memory strobes exist only while BUSY.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        win_d      = win_q;
        we_d       = we_q;
        gnt_d      = 2'b00;
        done_d     = 2'b00;
        err_d      = 2'b00;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        mem_we_d   = 1'b0;
        mem_addr_d = 16'h0000;
        mem_din_d  = 16'h0000;
        rd_s       = addr_readable(mem_addr_q) ? mem_dout : 16'h0000;
        case (state_q)
            ST_IDLE: begin
                if (|req_s) begin
                    state_d      = ST_BUSY;
                    win_d        = sel_s;
                    we_d         = sel_we_s;
                    gnt_d[sel_s] = 1'b1;
                    mem_addr_d   = sel_addr_s;
                    mem_din_d    = sel_wdata_s;
                    mem_we_d     = sel_we_s & addr_writable(sel_addr_s);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                state_d       = ST_DONE;
                done_d[win_q] = 1'b1;
                err_d[win_q]  = we_q ? ~addr_writable(mem_addr_q) : ~addr_readable(mem_addr_q);
                if (!we_q) begin
                    if (win_q) begin
                        rdata1_d = rd_s;
                    end else begin
                        rdata0_d = rd_s;
                    end
                end else begin
                    rdata0_d = rdata0_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                ptr_d   = ~win_q;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers, cleared asynchronously so reset aborts any transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= 1'b0;
            win_q      <= 1'b0;
            we_q       <= 1'b0;
            gnt_q      <= 2'b00;
            done_q     <= 2'b00;
            err_q      <= 2'b00;
            rdata0_q   <= 16'h0000;
            rdata1_q   <= 16'h0000;
            mem_we_q   <= 1'b0;
            mem_addr_q <= 16'h0000;
            mem_din_q  <= 16'h0000;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            win_q      <= win_d;
            we_q       <= we_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
        end
    end

    assign p0_gnt   = gnt_q[0];
    assign p1_gnt   = gnt_q[1];
    assign p0_done  = done_q[0];
    assign p1_done  = done_q[1];
    assign p0_err   = err_q[0];
    assign p1_err   = err_q[1];
    assign p0_rdata = rdata0_q;
    assign p1_rdata = rdata1_q;
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;

endmodule
